// File: rtl/bbfifo_pkg.sv
// Shared sizing constants and pointer helper for the 64-entry show-ahead FIFO.
package bbfifo_pkg;

    localparam int unsigned DEPTH = 64;
    localparam int unsigned PTR_W = 6;
    localparam int unsigned CNT_W = 7;

    // DEPTH is a power of two, so the natural PTR_W-bit wrap is the modulo.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
        return ptr + PTR_W'(1);
    endfunction

endpackage

// File: rtl/ram64x1_col.sv
// One 64x1 distributed RAM column: synchronous write port, asynchronous read port.
module ram64x1_col
    import bbfifo_pkg::*;
(
    input  logic             CLK,
    input  logic             D,
    input  logic             WE,
    input  logic [PTR_W-1:0] WADR,
    input  logic [PTR_W-1:0] RADR,
    output logic             O
);

    logic [DEPTH-1:0] mem;

    always_ff @(posedge CLK) begin
        if (WE) begin
            mem[WADR] <= D;
        end
    end

    assign O = mem[RADR];

endmodule

// File: rtl/bbfifo_64xw.sv
// Show-ahead FIFO, 64 deep x WIDTH: pointer/count control around distributed RAM columns.
module bbfifo_64xw
    import bbfifo_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned HALF_LEVEL = 32
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] DATA_IN,
    input  logic             WRITE,
    input  logic             READ,
    input  logic             CLR_ERR,
    output logic [WIDTH-1:0] DATA_OUT,
    output logic             DATA_PRESENT,
    output logic             HALF_FULL,
    output logic             FULL,
    output logic [CNT_W-1:0] COUNT,
    output logic             OVERFLOW,
    output logic             UNDERFLOW
);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             rd_acc, wr_acc;

    always_comb begin
        rd_acc = READ && (count_q != '0);
        // When full, a simultaneous pop frees the slot the write lands in.
        wr_acc = WRITE && ((count_q != CNT_W'(DEPTH)) || rd_acc);

        wr_ptr_d = wr_acc ? ptr_next(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = rd_acc ? ptr_next(rd_ptr_q) : rd_ptr_q;

        count_d = count_q;
        if (wr_acc && !rd_acc) begin
            count_d = count_q + 1'b1;
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - 1'b1;
        end

        // A new error event beats a same-cycle clear.
        ovf_d = ovf_q;
        if (WRITE && !wr_acc) begin
            ovf_d = 1'b1;
        end else if (CLR_ERR) begin
            ovf_d = 1'b0;
        end

        unf_d = unf_q;
        if (READ && !rd_acc) begin
            unf_d = 1'b1;
        end else if (CLR_ERR) begin
            unf_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    for (genvar b = 0; b < WIDTH; b++) begin : g_col
        ram64x1_col u_col (
            .CLK  (CLK),
            .D    (DATA_IN[b]),
            .WE   (wr_acc),
            .WADR (wr_ptr_q),
            .RADR (rd_ptr_q),
            .O    (DATA_OUT[b])
        );
    end

    assign DATA_PRESENT = (count_q != '0);
    assign FULL         = (count_q == CNT_W'(DEPTH));
    assign HALF_FULL    = (count_q >= CNT_W'(HALF_LEVEL));
    assign COUNT        = count_q;
    assign OVERFLOW     = ovf_q;
    assign UNDERFLOW    = unf_q;

endmodule

// File: tb/tb_bbfifo_64xw.sv
// Scoreboard bench for bbfifo_64xw: a reference queue tracks contents, flags and errors.
module tb_bbfifo_64xw;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic [7:0] DATA_IN = '0;
    logic       WRITE = 1'b0;
    logic       READ = 1'b0;
    logic       CLR_ERR = 1'b0;
    logic [7:0] DATA_OUT;
    logic       DATA_PRESENT;
    logic       HALF_FULL;
    logic       FULL;
    logic [6:0] COUNT;
    logic       OVERFLOW;
    logic       UNDERFLOW;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] sb[$];
    logic       m_ovf = 1'b0;
    logic       m_unf = 1'b0;

    bbfifo_64xw #(
        .WIDTH      (8),
        .HALF_LEVEL (32)
    ) u_dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .DATA_IN      (DATA_IN),
        .WRITE        (WRITE),
        .READ         (READ),
        .CLR_ERR      (CLR_ERR),
        .DATA_OUT     (DATA_OUT),
        .DATA_PRESENT (DATA_PRESENT),
        .HALF_FULL    (HALF_FULL),
        .FULL         (FULL),
        .COUNT        (COUNT),
        .OVERFLOW     (OVERFLOW),
        .UNDERFLOW    (UNDERFLOW)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_status();
        int n;
        n = sb.size();
        chk("count", 32'(COUNT), n);
        chk("data_present", 32'(DATA_PRESENT), 32'(n != 0));
        chk("full", 32'(FULL), 32'(n == 64));
        chk("half_full", 32'(HALF_FULL), 32'(n >= 32));
        chk("overflow", 32'(OVERFLOW), 32'(m_ovf));
        chk("underflow", 32'(UNDERFLOW), 32'(m_unf));
        if (n != 0) chk("head", 32'(DATA_OUT), 32'(sb[0]));
    endtask

    // One clock: compare the popped word before the edge, update the model, check after it.
    task automatic step(input logic wr, input logic rd, input logic [7:0] din, input logic clr);
        logic       rd_ok, wr_ok;
        logic [7:0] exp;
        rd_ok = rd && (sb.size() != 0);
        wr_ok = wr && ((sb.size() != 64) || rd_ok);
        if (rd_ok) begin
            exp = sb.pop_front();
            chk("pop", 32'(DATA_OUT), 32'(exp));
        end
        WRITE   = wr;
        READ    = rd;
        DATA_IN = din;
        CLR_ERR = clr;
        @(posedge CLK);
        #1;
        WRITE   = 1'b0;
        READ    = 1'b0;
        CLR_ERR = 1'b0;
        if (wr_ok) sb.push_back(din);
        if (wr && !wr_ok) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        if (rd && !rd_ok) m_unf = 1'b1;
        else if (clr) m_unf = 1'b0;
        chk_status();
    endtask

    initial begin
        #12;
        chk("reset_count", 32'(COUNT), 0);
        chk("reset_present", 32'(DATA_PRESENT), 0);
        chk("reset_flags", 32'({HALF_FULL, FULL, OVERFLOW, UNDERFLOW}), 0);
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;

        // Single word fall-through and pop.
        step(1'b1, 1'b0, 8'hA5, 1'b0);
        chk("a5_out", 32'(DATA_OUT), 32'h0A5);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        chk("a5_empty", 32'(DATA_PRESENT), 0);

        // Fill, overflow, drain.
        for (int i = 0; i < 64; i++) begin
            step(1'b1, 1'b0, 8'(i), 1'b0);
            chk("half_edge", 32'(HALF_FULL), 32'(i >= 31));
        end
        chk("full64", 32'(FULL), 1);
        step(1'b1, 1'b0, 8'hFF, 1'b0);
        chk("ovf65", 32'(OVERFLOW), 1);
        chk("cnt65", 32'(COUNT), 64);
        for (int i = 0; i < 64; i++) step(1'b0, 1'b1, 8'h00, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1);

        // Full with simultaneous read and write.
        for (int i = 0; i < 64; i++) step(1'b1, 1'b0, 8'(i), 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 8'(8'h80 + i), 1'b0);
        chk("full_rw_cnt", 32'(COUNT), 64);
        chk("full_rw_ovf", 32'(OVERFLOW), 0);
        chk("full_rw_head", 32'(DATA_OUT), 32'h0A);
        for (int i = 0; i < 64; i++) step(1'b0, 1'b1, 8'h00, 1'b0);

        // Empty with simultaneous read and write.
        step(1'b1, 1'b1, 8'h5C, 1'b0);
        chk("empty_rw_cnt", 32'(COUNT), 1);
        chk("empty_rw_unf", 32'(UNDERFLOW), 1);
        chk("empty_rw_out", 32'(DATA_OUT), 32'h5C);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("clr_unf", 32'(UNDERFLOW), 0);

        // Pointer wrap at steady occupancy 3.
        step(1'b1, 1'b0, 8'hC1, 1'b0);
        step(1'b1, 1'b0, 8'hC2, 1'b0);
        for (int i = 0; i < 200; i++) begin
            step(1'b1, 1'b1, 8'(i * 7 + 3), 1'b0);
            chk("wrap_cnt", 32'(COUNT), 3);
        end

        // Asynchronous reset mid-cycle with 17 words buffered.
        for (int i = 0; i < 14; i++) step(1'b1, 1'b0, 8'(8'h40 + i), 1'b0);
        chk("pre_rst_cnt", 32'(COUNT), 17);
        #2;
        RST_N = 1'b0;
        #1;
        chk("async_cnt", 32'(COUNT), 0);
        chk("async_present", 32'(DATA_PRESENT), 0);
        chk("async_flags", 32'({HALF_FULL, FULL, OVERFLOW, UNDERFLOW}), 0);
        sb.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
        chk("post_rst_present", 32'(DATA_PRESENT), 0);
        step(1'b1, 1'b0, 8'h11, 1'b0);
        chk("post_rst_out", 32'(DATA_OUT), 32'h11);
        step(1'b0, 1'b1, 8'h00, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bbfifo_64xw.md
Name: bbfifo_64xw

Overview:
- Show-ahead (first-word-fall-through) buffer, 64 entries deep and WIDTH bits wide.
- Built on 64x1 dual-port distributed RAM columns with a synchronous write port and an asynchronous read port.
- Sits directly upstream of the distributed RAM. It generates the write address, read address and write enable, and keeps occupancy and status flags.
- Used as the receive and transmit buffer between the KCPSM3 port interface and the UART/serial stages.

Parameters:
- WIDTH, 8: data width in bits; one 64x1 RAM column per bit.
- HALF_LEVEL, 32: occupancy at or above which HALF_FULL asserts; legal range 1..64.

Ports:
- CLK  input  1  single clock; all state changes on the rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- DATA_IN  input  WIDTH  write data.
- WRITE  input  1  write request, sampled on the rising CLK edge.
- READ  input  1  read request (pop), sampled on the rising CLK edge.
- CLR_ERR  input  1  synchronous clear of the sticky error flags.
- DATA_OUT  output  WIDTH  word at the head of the FIFO; asynchronous read of the RAM at the read pointer.
- DATA_PRESENT  output  1  high when count is not 0.
- HALF_FULL  output  1  high when count is at least HALF_LEVEL.
- FULL  output  1  high when count equals 64.
- COUNT  output  7  occupancy, 0..64.
- OVERFLOW  output  1  sticky: a write was dropped.
- UNDERFLOW  output  1  sticky: a read arrived while empty.

Behaviour:
- State registers:
  - wr_ptr[5:0], rd_ptr[5:0], count[6:0].
  - ovf and unf sticky bits.
- Storage: WIDTH instances of the storage sub-module.
  - WADR = wr_ptr, RADR = rd_ptr, WE = wr_acc.
  - Storage is not cleared by reset.
- Reset (RST_N=0, asynchronous): wr_ptr=0, rd_ptr=0, count=0, ovf=0, unf=0.
  - Outputs during and after reset: DATA_PRESENT=0, HALF_FULL=0, FULL=0, COUNT=0, OVERFLOW=0, UNDERFLOW=0.
  - DATA_OUT = RAM[0]; undefined content, don't-care while DATA_PRESENT=0.
  - Reset mid-operation discards all buffered data. The release edge is synchronised by the system; the block makes no requirement on it.
- Accept rules, per edge:
  - rd_acc = READ & (count != 0).
  - wr_acc = WRITE & ((count != 64) | rd_acc).
- Pointer and count updates:
  - wr_acc: RAM[wr_ptr] <= DATA_IN; wr_ptr <= wr_ptr+1, modulo 64 (natural 6-bit wrap from 63 to 0).
  - rd_acc: rd_ptr <= rd_ptr+1, modulo 64.
  - count: +1 if wr_acc only; -1 if rd_acc only; unchanged if both or neither.
- Simultaneous READ and WRITE:
  - Empty: the write is accepted and the read is ignored (it sets unf). Count becomes 1.
  - Full: both are accepted and count stays 64. The popped word is read before the overwrite, because the RAM read is asynchronous and the write lands on the edge.
  - Otherwise: both are accepted.
- Errors:
  - ovf <= 1 when WRITE & ~wr_acc.
  - unf <= 1 when READ & ~rd_acc.
  - CLR_ERR=1 clears both at the edge. If an error event occurs on the same edge as CLR_ERR, the set wins.
- Flags are decoded combinationally from the registered count, adding no extra latency:
  - DATA_PRESENT = count != 0.
  - FULL = count == 64.
  - HALF_FULL = count >= HALF_LEVEL.
- Latency:
  - A word written at edge N appears on DATA_OUT, with DATA_PRESENT=1, immediately after edge N when the FIFO was empty.
  - After a pop at edge N, DATA_OUT shows the next word after edge N.
- Ordering: strict FIFO order, no reordering, no word lost except writes that were dropped while full.

Decomposition:
- Shared package (bbfifo_pkg) holds:
  - DEPTH=64
  - PTR_W=6
  - CNT_W=7
  - a function computing the next pointer value modulo DEPTH.
- Sub-module ram64x1_col (generated WIDTH times):
  - ports CLK, D, WE, WADR[5:0], RADR[5:0], O;
  - synchronous write, asynchronous read, INIT=0.
- Controller logic stays in the top level.

Test Plan:
- Reset, then write 0xA5 once -> after that edge DATA_OUT=0xA5, DATA_PRESENT=1, COUNT=1. READ for one cycle -> COUNT=0, DATA_PRESENT=0.
- Write 0x00..0x3F on 64 consecutive edges:
  - FULL=1 and COUNT=64; HALF_FULL first rises after the 32nd write.
  - A 65th write of 0xFF -> OVERFLOW=1, COUNT=64.
  - Popping 64 times returns 0x00..0x3F in order.
- Fill to 64, then hold READ=WRITE=1 for 10 cycles with data 0x80..0x89:
  - COUNT stays 64; popped words are 0x00..0x09.
  - Draining then returns 0x0A..0x3F followed by 0x80..0x89.
- Empty FIFO with READ=WRITE=1 and DATA_IN=0x5C -> COUNT=1, UNDERFLOW=1, DATA_OUT=0x5C. CLR_ERR pulse -> UNDERFLOW=0.
- Pointer wrap: run 200 push/pop pairs with an incrementing pattern at steady occupancy 3 -> every read matches its write and COUNT never deviates from 3.
- Assert RST_N=0 asynchronously mid-cycle with COUNT=17 -> outputs clear immediately without a clock edge. After release, DATA_PRESENT=0 and a new write of 0x11 reads back 0x11.
